// File: rtl/data_serializer.sv
// data_serializer: streams loaded blocks as big-endian words with byte keeps and last marking; DATA_SERIALIZER_SKID_EN adds a one-block skid buffer
module data_serializer #(
  parameter int BLOCK_WIDTH = 128,
  parameter int WORD_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load_valid,
  output logic                              load_ready,
  input  logic [BLOCK_WIDTH-1:0]            load_data,
  input  logic [$clog2(BLOCK_WIDTH/8):0]    load_nbytes,
  input  logic                              load_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WORD_WIDTH-1:0]             out_data,
  output logic [WORD_WIDTH/8-1:0]           out_keep,
  output logic                              out_last
);
  localparam int NB = BLOCK_WIDTH / 8;
  localparam int WB = WORD_WIDTH / 8;
  localparam int NBW = $clog2(NB) + 1;
  localparam int CW = $clog2(BLOCK_WIDTH / WORD_WIDTH) + 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic [BLOCK_WIDTH-1:0] sr, src_d, src_m;
  logic [NBW-1:0] rem, src_n, nb_c;
  logic [CW-1:0] cnt, w, cnt_n;
  logic last_q, src_l, src_v, load_fire, xfer, fin, take;
  assign out_valid = state == SEND;
  assign out_data = sr[BLOCK_WIDTH-1 -: WORD_WIDTH];
  assign out_last = last_q && cnt == CW'(1);
  assign load_fire = load_valid && load_ready;
  assign xfer = out_valid && out_ready;
  assign fin = xfer && cnt == CW'(1);
  assign take = state == IDLE || fin;
`ifdef DATA_SERIALIZER_SKID_EN
  logic full, buf_l;
  logic [BLOCK_WIDTH-1:0] buf_d;
  logic [NBW-1:0] buf_n;
  assign load_ready = !full;
  assign src_v = full || load_fire;
  assign src_d = full ? buf_d : load_data;
  assign src_n = full ? buf_n : load_nbytes;
  assign src_l = full ? buf_l : load_last;
  always_ff @(posedge clk)
    if (rst) begin
      full <= 1'b0;
      buf_d <= '0;
      buf_n <= '0;
      buf_l <= 1'b0;
    end else if (take) full <= 1'b0;
    else if (load_fire) begin
      full <= 1'b1;
      buf_d <= load_data;
      buf_n <= load_nbytes;
      buf_l <= load_last;
    end
`else
  assign load_ready = state == IDLE;
  assign src_v = load_fire;
  assign src_d = load_data;
  assign src_n = load_nbytes;
  assign src_l = load_last;
`endif
  always_comb begin
    nb_c = src_n > NBW'(NB) ? NBW'(NB) : src_n;
    w = CW'((int'(nb_c) + WB - 1) / WB);
    cnt_n = (w == '0 && src_l) ? CW'(1) : w;
    src_m = src_d;
    for (int i = 0; i < NB; i++)
      if (i >= int'(nb_c)) src_m[BLOCK_WIDTH-1-8*i -: 8] = 8'h0;
    out_keep = '0;
    for (int j = 0; j < WB; j++)
      out_keep[WB-1-j] = j < int'(rem);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      rem <= '0;
      cnt <= '0;
      last_q <= 1'b0;
    end else if (take && src_v) begin
      sr <= src_m;
      rem <= nb_c;
      cnt <= cnt_n;
      last_q <= src_l;
      state <= cnt_n != '0 ? SEND : IDLE;
    end else if (xfer) begin
      sr <= sr << WORD_WIDTH;
      rem <= rem > NBW'(WB) ? rem - NBW'(WB) : '0;
      cnt <= cnt - CW'(1);
      state <= fin ? IDLE : SEND;
    end
endmodule

// File: doc/data_serializer.md
# data_serializer

Output-side serializer for the Ascon AEAD-128 datapath. It accepts a full block (ciphertext, plaintext or tag) from the core in one transfer and streams it to the host as big-endian words over a valid/ready handshake. It marks trailing partial bytes and the final word of a message. It is the read-out counterpart of the core's enable-written block registers and sits between the permutation/state logic and the host output bus.

## Interface
- BLOCK_WIDTH, 128, bits per loaded block; multiple of WORD_WIDTH
- WORD_WIDTH, 32, bits per output word; multiple of 8
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- load_valid  input  1  block offered by core
- load_ready  output  1  serializer can accept a block
- load_data  input  BLOCK_WIDTH  block; byte 0 = bits [BLOCK_WIDTH-1 -: 8]
- load_nbytes  input  $clog2(BLOCK_WIDTH/8)+1  valid bytes in block, 0..BLOCK_WIDTH/8
- load_last  input  1  block is final of message
- out_valid  output  1  word available
- out_ready  input  1  host accepts word
- out_data  output  WORD_WIDTH  word; invalid bytes forced to 0
- out_keep  output  WORD_WIDTH/8  byte enables, MSB = first byte
- out_last  output  1  final word of message

## Operation
- Load handshake: transfer on rising clk when load_valid && load_ready. Output handshake: transfer when out_valid && out_ready.
- FSM states:
  - IDLE: load_ready=1, out_valid=0. On a load transfer: register the block, compute the word count W = ceil(load_nbytes*8/WORD_WIDTH), latch load_last.
    - If W>0: go to SEND.
    - If W=0 and load_last=1: go to SEND with W forced to 1 (empty terminator word, out_keep=0, out_data=0, out_last=1).
    - If W=0 and load_last=0: drop the block and stay in IDLE.
  - SEND: out_valid=1. Present the most significant unsent word.
    - Each output transfer shifts the register left by WORD_WIDTH and decrements the remaining-word counter.
    - On the transfer of the final word, go to IDLE (or reload; see Configuration).
- out_keep: for a word at byte offset k, bit j (MSB-first) = 1 iff k+j < nbytes.
- out_data: byte lanes with keep=0 are driven 0.
- out_last = latched load_last && (this is the final word of the block).
- Output signals hold stable while out_valid && !out_ready (AXI-stream rule). out_valid never drops without a transfer.
- Inputs load_nbytes > BLOCK_WIDTH/8 are clamped to BLOCK_WIDTH/8.
- rst in any state: return to IDLE and discard the in-flight block. The reset applies regardless of out_ready.

## Timing
- Reset values: load_ready=1, out_valid=0, out_data=0, out_keep=0, out_last=0; internal counter and register 0.
- Latency: a load transfer at edge N gives out_valid=1 with the first word after edge N (cycle N+1).
- Throughput with out_ready held high: one word per cycle, so a full 128/32 block drains in 4 cycles.
- Without skid: load_ready=0 throughout SEND, so there is one idle output cycle between consecutive blocks.
- A load and the final-word output transfer in the same cycle are only possible with skid enabled.
- Counter width $clog2(BLOCK_WIDTH/WORD_WIDTH)+1. No wrap: the counter only decrements from W to 0.

## Configuration
- Macro DATA_SERIALIZER_SKID_EN.
- Defined:
  - Adds a one-entry holding buffer (data, nbytes, last). load_ready = !buffer_full, in all states.
  - On the final-word transfer, if the buffer is full, or a load transfer occurs in that same cycle, move that block directly into the shift register and stay in SEND. This gives zero bubble between blocks.
  - In IDLE, a buffered block is taken the next cycle.
- Undefined: no buffer. Behaviour is exactly the IDLE/SEND description above.

## Test plan
- Reset then full block: load 0x00112233_44556677_8899AABB_CCDDEEFF, nbytes=16, last=1, out_ready=1 -> words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on cycles N+1..N+4. keep=0xF on all four; out_last=1 only on the 4th word. load_ready returns to 1 at N+5.
- Partial block: same data, nbytes=5, last=1 -> 2 words: 0x00112233 keep=0xF, then 0x44000000 keep=0x8 with out_last=1.
- Empty terminator: nbytes=0, last=1 -> one word 0x00000000, keep=0x0, out_last=1. With nbytes=0, last=0 -> no output and load_ready stays 1.
- Backpressure: out_ready toggled 1,0,0,1,… on a full block -> out_data, out_keep and out_last stable during stalls; all 4 words delivered in order, with no duplicates.
- Reset mid-block: assert rst after the 2nd word -> next cycle out_valid=0, load_ready=1. A newly loaded block starts from its first word.
- Back-to-back (SKID_EN defined): two full blocks offered continuously, out_ready=1 -> 8 consecutive words with no gap cycle. Without the macro, exactly one out_valid=0 cycle between the blocks.
